// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: fixed IF/ID/EX/MEM/WB sequence,
// instruction latched into IR on leaving IF, Moore strobes decoded from state and IR.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic        pc_src,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic        taken;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       is_r, is_i, is_load, is_store, is_branch;
  logic       legal;

  // Shared R/I-type ALU decode; imm_form forces funct3 000 to ADD (no SUBI).
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic a,
                                            input logic imm_form);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (a && !imm_form) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = a ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IF;
      ir    <= NOP;
      taken <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          ir    <= instr;
          state <= S_ID;
        end
        S_ID:  state <= S_EX;
        S_EX: begin
          // Only a legal BEQ may redirect the PC.
          taken <= is_branch && legal && zero;
          state <= S_MEM;
        end
        S_MEM: state <= S_WB;
        S_WB:  state <= S_IF;
        default: state <= S_IF;
      endcase
    end
  end

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign alt       = ir[30];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  always_comb begin
    legal   = 1'b0;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    if (is_r) begin
      legal  = (funct3 != 3'b011);
      alu_op = alu_decode(funct3, alt, 1'b0);
    end else if (is_i) begin
      legal   = (funct3 != 3'b011);
      alu_op  = alu_decode(funct3, alt, 1'b1);
      alu_src = 1'b1;
    end else if (is_load) begin
      legal   = (funct3 == 3'b010);
      alu_src = 1'b1;
    end else if (is_store) begin
      legal   = (funct3 == 3'b010);
      alu_src = 1'b1;
    end else if (is_branch) begin
      legal  = (funct3 == 3'b000);
      alu_op = ALU_SUB;
    end
  end

  assign mem_read   = (state == S_MEM) && is_load  && legal;
  assign mem_write  = (state == S_MEM) && is_store && legal;
  assign reg_write  = (state == S_WB)  && legal && (is_r || is_i || is_load);
  assign mem_to_reg = (state == S_WB)  && is_load;
  assign pc_write   = (state == S_WB);
  assign pc_src     = (state == S_WB)  && taken;
  assign illegal    = (state == S_WB)  && !legal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus randomized instructions
// checked phase by phase against an instruction-level reference model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
  logic        pc_write, pc_src, illegal;

  int total  = 0;
  int passed = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_BAD} kind_t;

  typedef struct {
    kind_t      kind;
    logic       legal;
    logic [3:0] op;
    logic       src;
  } model_t;

  function automatic model_t model(input logic [31:0] w);
    model_t m;
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h33:   m.kind = K_R;
      7'h13:   m.kind = K_I;
      7'h03:   m.kind = K_LD;
      7'h23:   m.kind = K_ST;
      7'h63:   m.kind = K_BR;
      default: m.kind = K_BAD;
    endcase
    case (m.kind)
      K_R, K_I:   m.legal = (f3 != 3'd3);
      K_LD, K_ST: m.legal = (f3 == 3'd2);
      K_BR:       m.legal = (f3 == 3'd0);
      default:    m.legal = 1'b0;
    endcase
    m.src = (m.kind == K_I) || (m.kind == K_LD) || (m.kind == K_ST);
    case (m.kind)
      K_LD, K_ST: m.op = 4'd2;
      K_BR:       m.op = 4'd6;
      default: begin
        case (f3)
          3'd0: m.op = (m.kind == K_R && w[30]) ? 4'd6 : 4'd2;
          3'd1: m.op = 4'd9;
          3'd2: m.op = 4'd4;
          3'd4: m.op = 4'd5;
          3'd5: m.op = w[30] ? 4'd10 : 4'd8;
          3'd6: m.op = 4'd1;
          3'd7: m.op = 4'd0;
          default: m.op = 4'd2;
        endcase
      end
    endcase
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_reg_write"}, reg_write, 0);
    chk({tag, "_mem_to_reg"}, mem_to_reg, 0);
    chk({tag, "_pc_write"}, pc_write, 0);
    chk({tag, "_pc_src"}, pc_src, 0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask

  // Entered just after a falling edge in IF; runs phases 0..stop-1.
  // A full run (stop=5) returns just after the falling edge of the next IF.
  task automatic run_instr(input logic [31:0] w, input logic zex, input int stop);
    model_t m;
    m = model(w);
    for (int p = 0; p < stop; p++) begin
      instr = (p == 0) ? w : $urandom;
      zero  = (p == 2) ? zex : ~zex;
      #1;
      if (p > 0) begin
        chk("alu_src", alu_src, m.src);
        if (m.legal) chk("alu_op", alu_op, m.op);
      end
      chk("mem_read",   mem_read,   p == 3 && m.legal && m.kind == K_LD);
      chk("mem_write",  mem_write,  p == 3 && m.legal && m.kind == K_ST);
      chk("reg_write",  reg_write,  p == 4 && m.legal &&
                                    (m.kind == K_R || m.kind == K_I || m.kind == K_LD));
      chk("mem_to_reg", mem_to_reg, p == 4 && m.kind == K_LD);
      chk("pc_write",   pc_write,   p == 4);
      chk("pc_src",     pc_src,     p == 4 && m.legal && m.kind == K_BR && zex);
      chk("illegal",    illegal,    p == 4 && !m.legal);
      if (p < stop - 1 || stop == 5) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  logic [6:0]  ops [6];
  logic [31:0] w;

  initial begin
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
    ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h00;

    rst   = 1'b0;
    instr = 32'hDEAD_BEEF;
    zero  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_alu_op", alu_op, 4'b0010);
    chk("reset_alu_src", alu_src, 1'b1);
    rst = 1'b1;

    run_instr(32'h0020_81B3, 1'b0, 5);  // add
    run_instr(32'h4020_81B3, 1'b1, 5);  // sub
    run_instr(32'h4030_D093, 1'b0, 5);  // srai
    run_instr(32'h0080_A283, 1'b0, 5);  // lw
    run_instr(32'h0050_A423, 1'b1, 5);  // sw
    run_instr(32'h0020_8463, 1'b1, 5);  // beq taken
    run_instr(32'h0020_8463, 1'b0, 5);  // beq not taken, zero high elsewhere
    run_instr(32'hFFFF_FFFF, 1'b1, 5);  // illegal
    run_instr(32'h0020_B1B3, 1'b0, 5);  // R-type funct3 011 is illegal

    // Reset in the middle of a store's MEM cycle abandons the write at once.
    run_instr(32'h0050_A423, 1'b0, 4);
    #2 rst = 1'b0;
    #1;
    chk_idle("midreset");
    chk("midreset_alu_op", alu_op, 4'b0010);
    chk("midreset_alu_src", alu_src, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_instr(32'h0020_81B3, 1'b0, 5);

    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 5)];
      run_instr(w, 1'($urandom_range(0, 1)), 5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Ports SHALL be:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr  input  32  instruction word from instruction memory; valid during IF.
- zero  input  1  ALU zero flag; sampled in EX.
- alu_op  output  4  ALU operation code.
- alu_src  output  1  0 = op2 from rs2; 1 = op2 from immediate.
- mem_read  output  1  data-memory read strobe.
- mem_write  output  1  data-memory write strobe.
- reg_write  output  1  register-file write enable.
- mem_to_reg  output  1  1 = write-back data from memory; 0 = from ALU result.
- pc_write  output  1  PC update enable.
- pc_src  output  1  1 = branch target; 0 = PC+4.
- illegal  output  1  unsupported instruction flag.

REQ-002 alu_op encodings SHALL be: AND 0000, OR 0001, ADD 0010, SLT 0100, XOR 0101, SUB 0110, SRL 1000, SLL 1001, SRA 1010.

Function
REQ-003 The FSM SHALL have five states, with a fixed 5-cycle sequence per instruction: IF -> ID -> EX -> MEM -> WB -> IF.
REQ-004 On the clock edge leaving IF, the block SHALL latch instr into an internal IR; all decode SHALL use IR only.
REQ-005 Supported opcodes SHALL be R-type 0110011, I-ALU 0010011, LOAD 0000011 (funct3 010), STORE 0100011 (funct3 010), and BRANCH 1100011 (funct3 000, BEQ).
REQ-006 All other opcodes, and the funct3 values 011 and LOAD/STORE/BRANCH funct3 values not listed in REQ-005, SHALL be illegal.
REQ-007 R-type alu_op SHALL decode from funct3 and IR[30] as follows:
- 000: ADD if IR[30]=0, SUB if IR[30]=1.
- 001 SLL, 010 SLT, 100 XOR, 110 OR, 111 AND.
- 101: SRL if IR[30]=0, SRA if IR[30]=1.
REQ-008 I-ALU alu_op SHALL decode as R-type, except funct3 000 is always ADD.
REQ-009 LOAD and STORE SHALL use ADD; BRANCH SHALL use SUB.
REQ-010 alu_op and alu_src SHALL be combinational from IR and held stable from ID through WB.
REQ-011 alu_src SHALL be 1 for I-ALU, LOAD and STORE, and 0 otherwise.
REQ-012 In EX, for BRANCH, a taken flag SHALL register zero on the EX->MEM edge; for all other instructions taken SHALL be 0.
REQ-013 mem_read SHALL be 1 only in MEM for a legal LOAD.
REQ-014 mem_write SHALL be 1 only in MEM for a legal STORE.
REQ-015 reg_write SHALL be 1 only in WB for a legal R-type, I-ALU or LOAD.
REQ-016 mem_to_reg SHALL be 1 only in WB for LOAD.
REQ-017 pc_write SHALL be 1 only in WB, for every instruction including illegal ones.
REQ-018 pc_src SHALL equal taken during WB and be 0 in all other states.
REQ-019 illegal SHALL be 1 only in WB for an illegal IR, and SHALL suppress mem_read, mem_write and reg_write for that instruction.
REQ-020 All strobes SHALL be Moore outputs (state plus IR) with no dependence on instr or zero outside their sampling edges.

Reset
REQ-021 While rst=0, the state SHALL be IF, IR SHALL be 0x00000013 (NOP), taken SHALL be 0, and all strobes SHALL be 0.
REQ-022 While rst=0, alu_op SHALL be 0010 and alu_src SHALL be 1, as decoded from the NOP.
REQ-023 Asserting rst in any state SHALL immediately deassert every strobe; a pending memory or register write SHALL be abandoned.
REQ-024 After rst deasserts, the first rising edge SHALL latch instr; the first cycle after release is IF.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- instr=0x002081B3 (add): alu_op=0010, alu_src=0, reg_write=1 in WB only, pc_write=1 in WB, pc_src=0.
- instr=0x402081B3 (sub): alu_op=0110. instr with funct3 101 and IR[30]=1 on opcode 0010011 (srai): alu_op=1010, alu_src=1.
- instr=0x0080A283 (lw): alu_op=0010, alu_src=1, mem_read=1 in MEM only, reg_write=1 and mem_to_reg=1 in WB, mem_write never asserted.
- instr=0x0050A423 (sw): mem_write=1 in MEM only, reg_write=0 throughout.
- instr=0x00208463 (beq): zero=1 in EX gives pc_src=1 in WB; zero=0 in EX gives pc_src=0; zero toggled outside EX has no effect.
- instr=0xFFFFFFFF: illegal=1 in WB, no mem or reg strobes, pc_write=1; then rst=0 asserted mid-MEM of sw gives mem_write=0 the same cycle and state IF.
